// File: rtl/alu_issue_if.sv
// Instruction, issue and writeback signals of the alu_issue stage.
interface alu_issue_if;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_ready;
  logic        iss_valid;
  logic        iss_ready;
  logic [6:0]  iss_fun7;
  logic [2:0]  iss_fun3;
  logic [31:0] iss_rs1;
  logic [31:0] iss_rs2;
  logic [4:0]  iss_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        illegal;

  // Driver of instructions, ALU-ready and writebacks.
  modport master (
    output inst_valid, inst, iss_ready, wb_valid, wb_rd, wb_data,
    input  inst_ready, iss_valid, iss_fun7, iss_fun3, iss_rs1, iss_rs2,
           iss_rd, illegal
  );

  // The decode-and-issue stage itself.
  modport slave (
    input  inst_valid, inst, iss_ready, wb_valid, wb_rd, wb_data,
    output inst_ready, iss_valid, iss_fun7, iss_fun3, iss_rs1, iss_rs2,
           iss_rd, illegal
  );
endinterface

// File: rtl/alu_issue.sv
// RV32I OP/OP-IMM decode-and-issue stage: register file, per-register
// scoreboard and a single registered issue slot under valid/ready.
module alu_issue (
  input  logic      clk,
  input  logic      reset,
  alu_issue_if.slave bus
);
  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;

  state_t      state, state_nxt;
  logic [31:0] rf [32];
  logic [31:0] busy, busy_nxt, wb_clr, busy_live;

  logic [6:0]  opc, raw_f7;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2, rd;
  logic        is_op, legal;
  logic [6:0]  dec_f7;
  logic [31:0] imm;
  logic [31:0] opnd_a, opnd_b_reg, opnd_b;
  logic        hazard, slot_free, accept, take_illegal, ready;

  assign opc    = bus.inst[6:0];
  assign rd     = bus.inst[11:7];
  assign f3     = bus.inst[14:12];
  assign rs1    = bus.inst[19:15];
  assign rs2    = bus.inst[24:20];
  assign raw_f7 = bus.inst[31:25];

  // Opcode decode, legality and immediate formation
  always_comb begin
    is_op  = 1'b0;
    legal  = 1'b0;
    dec_f7 = raw_f7;
    imm    = '0;
    case (opc)
      OPC_OP: begin
        is_op = 1'b1;
        legal = (raw_f7 == 7'h00) ||
                (raw_f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
      end
      OPC_IMM: begin
        if (f3 == 3'b001 || f3 == 3'b101) begin
          imm   = {27'd0, bus.inst[24:20]};
          legal = (raw_f7 == 7'h00) || (f3 == 3'b101 && raw_f7 == 7'h20);
        end else begin
          dec_f7 = '0;
          imm    = {{20{bus.inst[31]}}, bus.inst[31:20]};
          legal  = 1'b1;
        end
      end
      default: legal = 1'b0;
    endcase
  end

  // Operand read with same-cycle writeback bypass; x0 reads as zero
  always_comb begin
    if (rs1 == 5'd0)                            opnd_a = '0;
    else if (bus.wb_valid && bus.wb_rd == rs1)  opnd_a = bus.wb_data;
    else                                        opnd_a = rf[rs1];
    if (rs2 == 5'd0)                            opnd_b_reg = '0;
    else if (bus.wb_valid && bus.wb_rd == rs2)  opnd_b_reg = bus.wb_data;
    else                                        opnd_b_reg = rf[rs2];
    opnd_b = is_op ? opnd_b_reg : imm;
  end

  // Hazard check against busy bits, ignoring bits cleared this cycle
  always_comb begin
    wb_clr    = bus.wb_valid ? (32'd1 << bus.wb_rd) : '0;
    busy_live = busy & ~wb_clr;
    hazard    = busy_live[rs1] | (is_op & busy_live[rs2]) | busy_live[rd];
  end

  // Handshake and issue-slot next state
  always_comb begin
    state_nxt    = state;
    ready        = 1'b0;
    accept       = 1'b0;
    take_illegal = 1'b0;
    slot_free    = (state == EMPTY) || bus.iss_ready;
    if (bus.inst_valid) begin
      if (!legal) begin
        ready        = 1'b1;
        take_illegal = 1'b1;
      end else if (slot_free && !hazard) begin
        ready  = 1'b1;
        accept = 1'b1;
      end
    end
    case (state)
      EMPTY:   if (accept) state_nxt = FULL;
      FULL:    if (bus.iss_ready && !accept) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  assign bus.inst_ready = ready;
  assign bus.iss_valid  = (state == FULL);

  // Scoreboard next value: clear on writeback, then set on accept (set wins)
  always_comb begin
    busy_nxt = busy & ~wb_clr;
    if (accept && rd != 5'd0) busy_nxt[rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Issue-slot state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Scoreboard register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  // Issue packet fields load on accept, otherwise hold
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.iss_fun7 <= '0;
      bus.iss_fun3 <= '0;
      bus.iss_rs1  <= '0;
      bus.iss_rs2  <= '0;
      bus.iss_rd   <= '0;
    end else if (accept) begin
      bus.iss_fun7 <= dec_f7;
      bus.iss_fun3 <= f3;
      bus.iss_rs1  <= opnd_a;
      bus.iss_rs2  <= opnd_b;
      bus.iss_rd   <= rd;
    end
  end

  // One-cycle pulse per consumed illegal instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.illegal <= 1'b0;
    else       bus.illegal <= take_illegal;
  end

  // Register file write port; x0 is never written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) rf[i] <= '0;
    end else if (bus.wb_valid && bus.wb_rd != 5'd0) begin
      rf[bus.wb_rd] <= bus.wb_data;
    end
  end
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios with literal expectations, then
// randomized traffic, all checked against a behavioural model each cycle.
module tb_alu_issue;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_issue_if bus ();
  alu_issue u_dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic [31:0] m_rf [32];
  bit          m_busy [32];
  bit          m_full, m_ill;
  logic [6:0]  m_f7;
  logic [2:0]  m_f3;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // What the instruction means, straight from the ISA subset rules
  task automatic mdecode(input logic [31:0] w, output bit legal, output bit use2,
                         output logic [6:0] f7, output logic [31:0] imm);
    logic [6:0] op;
    logic [2:0] f3;
    op = w[6:0];
    f3 = w[14:12];
    legal = 0; use2 = 0; f7 = w[31:25]; imm = 0;
    if (op == 7'b0110011) begin
      use2  = 1;
      legal = (w[31:25] == 7'h00) || (w[31:25] == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    end else if (op == 7'b0010011) begin
      if (f3 == 3'd1 || f3 == 3'd5) begin
        imm   = {27'd0, w[24:20]};
        legal = (w[31:25] == 7'h00) || (f3 == 3'd5 && w[31:25] == 7'h20);
      end else begin
        f7    = 7'h00;
        imm   = {{20{w[31]}}, w[31:20]};
        legal = 1;
      end
    end
  endtask

  function automatic bit blocked(input logic [4:0] r, input bit wv, input logic [4:0] wrd);
    return m_busy[r] && !(wv && wrd == r);
  endfunction

  task automatic model_reset();
    m_full = 0; m_ill = 0;
    for (int i = 0; i < 32; i++) begin m_rf[i] = '0; m_busy[i] = 0; end
  endtask

  // Compare registered outputs with the model
  task automatic compare_outputs();
    chk("iss_valid", {31'd0, bus.iss_valid}, {31'd0, m_full});
    chk("illegal", {31'd0, bus.illegal}, {31'd0, m_ill});
    if (m_full) begin
      chk("iss_fun7", {25'd0, bus.iss_fun7}, {25'd0, m_f7});
      chk("iss_fun3", {29'd0, bus.iss_fun3}, {29'd0, m_f3});
      chk("iss_rs1", bus.iss_rs1, m_a);
      chk("iss_rs2", bus.iss_rs2, m_b);
      chk("iss_rd", {27'd0, bus.iss_rd}, {27'd0, m_rd});
    end
  endtask

  // One clock: drive at negedge, check inst_ready, advance model at posedge
  task automatic cycle(input bit iv, input logic [31:0] ins, input bit ir,
                       input bit wv, input logic [4:0] wrd, input logic [31:0] wd,
                       output bit rdy);
    bit legal, use2, exp_rdy, acc;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] after [32];
    logic [4:0]  r1, r2, rd;
    bus.inst_valid = iv; bus.inst = ins; bus.iss_ready = ir;
    bus.wb_valid = wv; bus.wb_rd = wrd; bus.wb_data = wd;
    mdecode(ins, legal, use2, f7, imm);
    r1 = ins[19:15]; r2 = ins[24:20]; rd = ins[11:7];
    exp_rdy = iv && (!legal || ((!m_full || ir) && !blocked(r1, wv, wrd) &&
              !(use2 && blocked(r2, wv, wrd)) && !blocked(rd, wv, wrd)));
    #1;
    chk("inst_ready", {31'd0, bus.inst_ready}, {31'd0, exp_rdy});
    rdy = bus.inst_ready;
    @(posedge clk);
    // Operands observe this cycle's writeback
    after = m_rf;
    if (wv && wrd != 0) after[wrd] = wd;
    acc = iv && legal && exp_rdy;
    if (acc) begin
      m_f7 = f7; m_f3 = ins[14:12]; m_rd = rd;
      m_a = after[r1];
      m_b = use2 ? after[r2] : imm;
    end
    m_full = acc || (m_full && !ir);
    m_ill  = iv && !legal;
    if (wv) m_busy[wrd] = 0;
    if (acc && rd != 0) m_busy[rd] = 1;
    m_rf = after;
    #1;
    compare_outputs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.inst_valid = 0; bus.iss_ready = 0; bus.wb_valid = 0;
    bus.inst = '0; bus.wb_rd = '0; bus.wb_data = '0;
    #1;
    model_reset();
    chk("rst_iss_valid", {31'd0, bus.iss_valid}, 32'd0);
    chk("rst_illegal", {31'd0, bus.illegal}, 32'd0);
    chk("rst_fields", {bus.iss_fun7, bus.iss_fun3, bus.iss_rd}, 32'd0);
    chk("rst_rs1", bus.iss_rs1, 32'd0);
    chk("rst_rs2", bus.iss_rs2, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [2:0]  f3;
    logic [6:0]  f7;
    int unsigned k, s;
    k  = $urandom_range(0, 9);
    s  = $urandom_range(0, 3);
    f3 = 3'($urandom);
    w  = $urandom;
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    w[14:12] = f3;
    f7 = (s == 0) ? 7'h00 : (s == 1) ? 7'h20 : (s == 2) ? 7'h01 : 7'h00;
    if (k <= 3) begin
      w[6:0] = 7'b0110011; w[31:25] = f7;
    end else if (k <= 7) begin
      w[6:0] = 7'b0010011;
      if (f3 == 3'd1 || f3 == 3'd5) w[31:25] = f7;
    end else begin
      if (w[6:0] == 7'b0110011 || w[6:0] == 7'b0010011) w[6:0] = 7'b1101111;
    end
    return w;
  endfunction

  initial begin
    bit r;
    logic [4:0] q [$];
    bit wv, iv, ir;
    logic [4:0] wrd;
    @(negedge clk);
    do_reset();

    // Load x1=5, x2=7 then ADD x3,x1,x2
    cycle(0, 32'h0, 1, 1, 5'd1, 32'd5, r);
    cycle(0, 32'h0, 1, 1, 5'd2, 32'd7, r);
    cycle(1, 32'h002081B3, 1, 0, 5'd0, 32'd0, r);
    chk("add_valid", {31'd0, bus.iss_valid}, 32'd1);
    chk("add_rs1", bus.iss_rs1, 32'd5);
    chk("add_rs2", bus.iss_rs2, 32'd7);
    chk("add_rd", {27'd0, bus.iss_rd}, 32'd3);
    // SUB x4 then SRAI x5 back to back
    cycle(1, 32'h40208233, 1, 0, 5'd0, 32'd0, r);
    chk("sub_fun7", {25'd0, bus.iss_fun7}, 32'h20);
    chk("sub_fun3", {29'd0, bus.iss_fun3}, 32'd0);
    cycle(1, 32'h4030D293, 1, 0, 5'd0, 32'd0, r);
    chk("srai_rdy", {31'd0, r}, 32'd1);
    chk("srai_fun7", {25'd0, bus.iss_fun7}, 32'h20);
    chk("srai_fun3", {29'd0, bus.iss_fun3}, 32'd5);
    chk("srai_rs2", bus.iss_rs2, 32'd3);
    chk("srai_rd", {27'd0, bus.iss_rd}, 32'd5);
    // ADDI x6,x0,-1 then dependent ADD x7,x6,x0
    cycle(1, 32'hFFF00313, 1, 0, 5'd0, 32'd0, r);
    chk("addi_rs1", bus.iss_rs1, 32'd0);
    chk("addi_rs2", bus.iss_rs2, 32'hFFFFFFFF);
    chk("addi_fun7", {25'd0, bus.iss_fun7}, 32'd0);
    cycle(1, 32'h000303B3, 1, 0, 5'd0, 32'd0, r);
    chk("dep_stall", {31'd0, r}, 32'd0);
    cycle(1, 32'h000303B3, 1, 1, 5'd6, 32'hFFFFFFFF, r);
    chk("dep_accept", {31'd0, r}, 32'd1);
    chk("dep_rs1", bus.iss_rs1, 32'hFFFFFFFF);
    // Backpressure: ADDI x9,x0,1 waits while the packet is held
    for (int i = 0; i < 3; i++) begin
      cycle(1, 32'h00100493, 0, 0, 5'd0, 32'd0, r);
      chk("bp_rdy", {31'd0, r}, 32'd0);
      chk("bp_rd_hold", {27'd0, bus.iss_rd}, 32'd7);
      chk("bp_rs1_hold", bus.iss_rs1, 32'hFFFFFFFF);
    end
    cycle(1, 32'h00100493, 1, 0, 5'd0, 32'd0, r);
    chk("bp_release", {31'd0, r}, 32'd1);
    chk("bp_new_rd", {27'd0, bus.iss_rd}, 32'd9);
    // Illegal: JAL, then ADD with fun7=0x01
    cycle(1, 32'h0000006F, 1, 0, 5'd0, 32'd0, r);
    chk("jal_rdy", {31'd0, r}, 32'd1);
    chk("jal_illegal", {31'd0, bus.illegal}, 32'd1);
    chk("jal_no_issue", {31'd0, bus.iss_valid}, 32'd0);
    cycle(0, 32'h0, 1, 0, 5'd0, 32'd0, r);
    chk("ill_pulse_end", {31'd0, bus.illegal}, 32'd0);
    cycle(1, 32'h022081B3, 1, 0, 5'd0, 32'd0, r);
    chk("f7_01_illegal", {31'd0, bus.illegal}, 32'd1);
    // Reset while FULL with x3 still busy
    cycle(1, 32'h00200513, 0, 0, 5'd0, 32'd0, r);
    chk("full_pre_rst", {31'd0, bus.iss_valid}, 32'd1);
    do_reset();
    cycle(1, 32'h00318433, 1, 0, 5'd0, 32'd0, r);
    chk("post_rst_rdy", {31'd0, r}, 32'd1);
    chk("post_rst_rs1", bus.iss_rs1, 32'd0);
    chk("post_rst_rs2", bus.iss_rs2, 32'd0);
    chk("post_rst_rd", {27'd0, bus.iss_rd}, 32'd8);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      q.delete();
      for (int i = 1; i < 32; i++) if (m_busy[i]) q.push_back(5'(i));
      wv = 0; wrd = '0;
      if (q.size() != 0 && $urandom_range(0, 9) < 4) begin
        wv = 1; wrd = q[$urandom_range(0, q.size() - 1)];
      end else if ($urandom_range(0, 9) == 0) begin
        wv = 1; wrd = 5'($urandom_range(0, 7));
      end
      iv = ($urandom_range(0, 9) < 8);
      ir = ($urandom_range(0, 9) < 7);
      cycle(iv, rand_inst(), ir, wv, wrd, $urandom, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
# alu_issue

Decode-and-issue stage placed directly upstream of the ALU. Accepts 32-bit RV32I instructions, decodes OP and OP-IMM into ALU controls, reads operands from an internal 32x32 register file, and presents one registered issue packet per cycle under a valid/ready handshake. Results return through a writeback port. A per-register scoreboard stalls instructions that read or overwrite a register with a result still in flight.

## Interface
- No parameters. XLEN 32 and 32 architectural registers are fixed.
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- inst_valid  in  1  instruction present on inst
- inst  in  32  RV32I instruction word
- inst_ready  out  1  instruction is consumed this cycle (combinational)
- iss_valid  out  1  issue packet valid
- iss_ready  in  1  ALU accepts packet
- iss_fun7  out  7  ALU fun7
- iss_fun3  out  3  ALU fun3
- iss_rs1  out  32  operand 1 value
- iss_rs2  out  32  operand 2 value, or immediate
- iss_rd  out  5  destination register
- wb_valid  in  1  writeback strobe
- wb_rd  in  5  writeback register
- wb_data  in  32  writeback value
- illegal  out  1  one-cycle pulse: an unsupported instruction was consumed

## Operation
- Decode inst[6:0]:
  - 0110011 (OP): fun3=inst[14:12], fun7=inst[31:25].
    - Legal if fun7=0000000, or fun7=0100000 with fun3 000 or 101.
    - Operands: rs1=x[inst[19:15]], rs2=x[inst[24:20]].
  - 0010011 (OP-IMM), fun3 001/101 (shifts): fun7=inst[31:25].
    - Legal if fun7=0000000, or fun3=101 with fun7=0100000.
    - rs2 = zero-extended inst[24:20].
  - 0010011 (OP-IMM), other fun3: fun7 forced to 0000000; rs2 = sign-extended inst[31:20].
  - Any other opcode, or a failed legality check, is illegal.
- Register file:
  - Read x0 returns 0. A write to x0 is ignored.
  - Read-during-write bypass: if wb_valid and wb_rd equals a source register (nonzero), the operand takes wb_data.
  - Writeback writes the register whether or not its busy bit is set.
- Scoreboard busy[31:1] (bit 0 always 0):
  - Hazard when busy is set for any used source register (rs1 always; rs2 for OP only) or for rd.
  - A busy bit cleared by wb_valid in the same cycle is not a hazard.
  - Issue accept with rd!=0 sets busy[rd].
  - wb_valid clears busy[wb_rd].
  - Simultaneous set and clear of the same bit: the set wins.
- Output register state is EMPTY (iss_valid=0) or FULL (iss_valid=1):
  - slot_free = !iss_valid || iss_ready.
  - Legal instruction: inst_ready = slot_free && !hazard.
  - Illegal instruction: inst_ready = 1 with no hazard check. On consume, illegal=1 next cycle; no packet is issued and the scoreboard is unchanged.
  - Accept loads the iss_* fields and sets iss_valid=1.
  - FULL with iss_ready and no accept goes to EMPTY.
  - FULL with iss_ready and an accept stays FULL with the new packet (back-to-back issue).
  - FULL without iss_ready holds all iss_* fields stable.
- inst_ready is 0 whenever inst_valid is 0.

## Timing
- Reset:
  - iss_valid=0, illegal=0, iss_fun7/fun3/rs1/rs2/rd=0.
  - All busy bits 0; all registers 0.
- Reset asserted mid-operation drops the pending packet and clears the scoreboard. Writebacks that arrive after reset for lost packets still write the register file.
- Latency: instruction accepted in cycle N is on iss_* in cycle N+1.
- Throughput: one instruction per cycle when there is no hazard and iss_ready=1.
- Dependent instruction: earliest accept is the cycle its producer's wb_valid is high (same-cycle bypass).
- illegal pulses exactly one cycle per illegal instruction consumed.

## Test plan
- Writeback x1=5, x2=7, then issue ADD x3,x1,x2 (0x002081B3) -> next cycle iss_valid=1, fun3=0, fun7=0x00, rs1=5, rs2=7, rd=3; busy[3]=1.
- SUB x4,x1,x2 (0x40208233) followed by SRAI x5,x1,3 (0x4030D293) with iss_ready held high -> two consecutive packets: first fun7=0x20/fun3=0; second fun7=0x20, fun3=5, rs2=3, rd=5.
- ADDI x6,x0,-1 (0xFFF00313) -> rs1=0, rs2=0xFFFFFFFF, fun7=0. Then ADD x7,x6,x0 is stalled (inst_ready=0) until wb_valid with wb_rd=6 and wb_data=0xFFFFFFFF; it is accepted that same cycle with rs1=0xFFFFFFFF.
- Hold iss_ready=0 for 3 cycles with a packet pending -> iss_* stable and inst_ready=0. Raise iss_ready -> the next instruction is accepted in that same cycle.
- Issue 0x0000006F (JAL) -> inst_ready=1, illegal=1 for one cycle, iss_valid stays 0, scoreboard unchanged. Issue ADD with fun7=0x01 -> illegal.
- Assert reset while FULL with busy[3]=1 -> iss_valid=0 and busy cleared immediately. ADD x8,x3,x3 then issues without stall, with rs1=rs2=0.
